ulpi_reg_arbiter: RTL and testbench

ULPI_REG_ARBITER -- requirements
Module: ulpi_reg_arbiter

---
 rtl/ulpi_reg_arbiter.sv | 159 +++++++++++++++
 tb/tb_ulpi_reg_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter giving two requesters access to the ULPI PHY register port,
// with per-transaction retry on PHY failure, link drop or WAIT timeout.
module ulpi_reg_arbiter #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 1023,
  localparam int unsigned ADDR_W   = 6,
  localparam int unsigned DATA_W   = 8
) (
  input  logic              CLK_60M,
  input  logic              NRST_A_USB,
  input  logic              R0_REQ,
  input  logic              R0_RW,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_WDATA,
  output logic              R0_ACK,
  output logic              R0_FAIL,
  input  logic              R1_REQ,
  input  logic              R1_RW,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_WDATA,
  output logic              R1_ACK,
  output logic              R1_FAIL,
  output logic [DATA_W-1:0] RDATA,
  input  logic              ULPI_READY,
  output logic              REG_EN,
  output logic              REG_RW,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_DATA_I,
  input  logic [DATA_W-1:0] REG_DATA_O,
  input  logic              REG_DONE,
  input  logic              REG_FAIL,
  output logic              BUSY,
  output logic              GRANT
);

  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // The attempt expires on the TIMEOUT-th silent WAIT cycle; the counter never reaches TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [RTY_W-1:0]    rty_q, rty_d;
  logic                last_grant_q, last_grant_d;
  logic                win;
  logic                reg_en_d, reg_rw_d, grant_d, busy_d;
  logic [ADDR_W-1:0]   reg_addr_d;
  logic [DATA_W-1:0]   reg_data_d, rdata_d;
  logic                ack0_d, ack1_d, fail0_d, fail1_d;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    rty_d        = rty_q;
    last_grant_d = last_grant_q;
    win          = 1'b0;
    reg_en_d     = 1'b0;
    reg_rw_d     = REG_RW;
    reg_addr_d   = REG_ADDR;
    reg_data_d   = REG_DATA_I;
    grant_d      = GRANT;
    rdata_d      = RDATA;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    fail0_d      = 1'b0;
    fail1_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ULPI_READY && (R0_REQ || R1_REQ)) begin
          win        = (R0_REQ && R1_REQ) ? ~last_grant_q : R1_REQ;
          grant_d    = win;
          reg_rw_d   = win ? R1_RW    : R0_RW;
          reg_addr_d = win ? R1_ADDR  : R0_ADDR;
          reg_data_d = win ? R1_WDATA : R0_WDATA;
          rty_d      = '0;
          reg_en_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // DONE takes priority over any simultaneous failure indication
        if (REG_DONE) begin
          ack0_d  = ~GRANT;
          ack1_d  = GRANT;
          if (!REG_RW) rdata_d = REG_DATA_O;
          state_d = S_RESP;
        end else if (REG_FAIL || !ULPI_READY || (tmo_q == TMO_LAST)) begin
          if (rty_q == RTY_MAX) begin
            ack0_d  = ~GRANT;
            ack1_d  = GRANT;
            fail0_d = ~GRANT;
            fail1_d = GRANT;
            state_d = S_RESP;
          end else begin
            rty_d    = rty_q + RTY_W'(1);
            reg_en_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        last_grant_d = GRANT;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      rty_q        <= '0;
      last_grant_q <= 1'b1;
      REG_EN       <= 1'b0;
      REG_RW       <= 1'b0;
      REG_ADDR     <= '0;
      REG_DATA_I   <= '0;
      GRANT        <= 1'b0;
      BUSY         <= 1'b0;
      RDATA        <= '0;
      R0_ACK       <= 1'b0;
      R1_ACK       <= 1'b0;
      R0_FAIL      <= 1'b0;
      R1_FAIL      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      rty_q        <= rty_d;
      last_grant_q <= last_grant_d;
      REG_EN       <= reg_en_d;
      REG_RW       <= reg_rw_d;
      REG_ADDR     <= reg_addr_d;
      REG_DATA_I   <= reg_data_d;
      GRANT        <= grant_d;
      BUSY         <= busy_d;
      RDATA        <= rdata_d;
      R0_ACK       <= ack0_d;
      R1_ACK       <= ack1_d;
      R0_FAIL      <= fail0_d;
      R1_FAIL      <= fail1_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter: scripted PHY responder plus a
// transaction-level model predicting order, attempts, latency and read data.
module tb_ulpi_reg_arbiter;

  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 1023;
  localparam int ATTEMPTS = MAX_RETRY + 1;
  localparam int K_DONE = 0, K_FAIL = 1, K_BOTH = 2, K_SILENT = 3;

  typedef struct {int kind; int dly; logic [7:0] data;} plan_t;
  typedef struct {logic rw; logic [5:0] addr; logic [7:0] data; int cyc;} seen_t;
  typedef struct {bit to; int cyc; logic a0, a1, f0, f1, gr, busy; logic [7:0] rd; int ens;} obs_t;
  typedef struct {int idx; int att; bit fail; int lat; logic [7:0] rd;
                  logic rw; logic [5:0] addr; logic [7:0] wd;} exp_t;

  logic       CLK_60M, NRST_A_USB;
  logic       R0_REQ, R0_RW, R1_REQ, R1_RW;
  logic [5:0] R0_ADDR, R1_ADDR;
  logic [7:0] R0_WDATA, R1_WDATA;
  logic       R0_ACK, R0_FAIL, R1_ACK, R1_FAIL;
  logic [7:0] RDATA;
  logic       ULPI_READY, REG_EN, REG_RW, REG_DONE, REG_FAIL, BUSY, GRANT;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I, REG_DATA_O;

  int checks, errors;
  int en_cnt, cyc_now;
  plan_t plan_q[$];
  seen_t seen_q[$];
  logic       lg_model;
  logic [7:0] rdata_model;

  ulpi_reg_arbiter #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB),
    .R0_REQ(R0_REQ), .R0_RW(R0_RW), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
    .R0_ACK(R0_ACK), .R0_FAIL(R0_FAIL),
    .R1_REQ(R1_REQ), .R1_RW(R1_RW), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
    .R1_ACK(R1_ACK), .R1_FAIL(R1_FAIL),
    .RDATA(RDATA), .ULPI_READY(ULPI_READY),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
    .REG_DATA_O(REG_DATA_O), .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL),
    .BUSY(BUSY), .GRANT(GRANT)
  );

  initial begin
    CLK_60M = 1'b0;
    forever #8 CLK_60M = ~CLK_60M;
  end

  // PHY model: on each strobe pop a plan entry and answer in WAIT cycle 'dly'
  initial begin
    int cd;
    plan_t cur;
    cd = 0;
    cur = '{K_DONE, 1, 8'h00};
    en_cnt = 0;
    cyc_now = 0;
    REG_DONE = 1'b0;
    REG_FAIL = 1'b0;
    REG_DATA_O = 8'h00;
    forever begin
      @(negedge CLK_60M);
      cyc_now++;
      REG_DONE = 1'b0;
      REG_FAIL = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          REG_DONE   = (cur.kind == K_DONE || cur.kind == K_BOTH);
          REG_FAIL   = (cur.kind == K_FAIL || cur.kind == K_BOTH);
          REG_DATA_O = (cur.kind == K_FAIL) ? 8'($urandom) : cur.data;
        end
      end
      if (REG_EN) begin
        en_cnt++;
        seen_q.push_back('{REG_RW, REG_ADDR, REG_DATA_I, cyc_now});
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur = '{K_DONE, 1, 8'($urandom)};
        cd = (cur.kind == K_SILENT) ? 0 : cur.dly;
      end
    end
  end

  // Waits (bounded) for an ACK and snapshots the outputs; makes no comparisons.
  task automatic serve(input int limit, input int drop_at, output obs_t o);
    int e0;
    e0 = en_cnt;
    seen_q.delete();
    o.to = 1'b1;
    o.cyc = 0;
    while (o.cyc < limit) begin
      @(negedge CLK_60M);
      o.cyc++;
      if (drop_at != 0 && o.cyc == drop_at) begin
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
      end
      if (R0_ACK || R1_ACK) begin
        o.to = 1'b0;
        break;
      end
    end
    o.a0 = R0_ACK; o.a1 = R1_ACK; o.f0 = R0_FAIL; o.f1 = R1_FAIL;
    o.gr = GRANT; o.busy = BUSY; o.rd = RDATA; o.ens = en_cnt - e0;
  endtask

  task automatic test_reset;
    NRST_A_USB = 1'b0;
    repeat (3) @(negedge CLK_60M);
    checks++;
    if ({R0_ACK, R1_ACK, R0_FAIL, R1_FAIL, REG_EN, REG_RW, BUSY, GRANT} !== 8'h00)
      begin errors++; $display("FAIL reset_flags: got %b want 00000000",
        {R0_ACK, R1_ACK, R0_FAIL, R1_FAIL, REG_EN, REG_RW, BUSY, GRANT}); end
    checks++;
    if ({RDATA, REG_ADDR, REG_DATA_I} !== 22'h0)
      begin errors++; $display("FAIL reset_data: got %h want 0", {RDATA, REG_ADDR, REG_DATA_I}); end
    NRST_A_USB = 1'b1;
    repeat (2) @(negedge CLK_60M);
    checks++;
    if ({BUSY, REG_EN} !== 2'b00)
      begin errors++; $display("FAIL idle_after_reset: got %b want 00", {BUSY, REG_EN}); end
    lg_model = 1'b1;
    rdata_model = 8'h00;
  endtask

  task automatic test_contention;
    obs_t o;
    plan_q.push_back('{K_DONE, 1, 8'h41});
    plan_q.push_back('{K_DONE, 3, 8'h42});
    R0_RW = 1'b0; R0_ADDR = 6'h01; R1_RW = 1'b0; R1_ADDR = 6'h02;
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    serve(100, 0, o);
    R0_REQ = 1'b0;
    checks++;
    if ({o.to, o.a0, o.a1, o.f0, o.gr, o.rd} !== {5'b01000, 8'h41})
      begin errors++; $display("FAIL contention_first: got to%0d a%b%b f%b g%b rd%h want R0 rd41",
        o.to, o.a0, o.a1, o.f0, o.gr, o.rd); end
    checks++;
    if (o.cyc + 1 != 4 || seen_q.size() != 1 || seen_q[0].addr !== 6'h01)
      begin errors++; $display("FAIL contention_first_lat: got cyc %0d strobes %0d want 4 1",
        o.cyc + 1, seen_q.size()); end
    serve(100, 0, o);
    R1_REQ = 1'b0;
    checks++;
    if ({o.to, o.a0, o.a1, o.f1, o.gr, o.rd} !== {5'b00101, 8'h42})
      begin errors++; $display("FAIL contention_second: got to%0d a%b%b f%b g%b rd%h want R1 rd42",
        o.to, o.a0, o.a1, o.f1, o.gr, o.rd); end
    checks++;
    if (o.cyc != 6 || seen_q.size() != 1 || seen_q[0].addr !== 6'h02)
      begin errors++; $display("FAIL contention_second_lat: got cyc %0d strobes %0d want 6 1",
        o.cyc, seen_q.size()); end
    lg_model = 1'b1;
    rdata_model = 8'h42;
    @(negedge CLK_60M);
  endtask

  task automatic test_single_write;
    obs_t o;
    plan_q.push_back('{K_DONE, 2, 8'h5A});
    R0_RW = 1'b1; R0_ADDR = 6'h0A; R0_WDATA = 8'h00; R0_REQ = 1'b1;
    serve(100, 0, o);
    R0_REQ = 1'b0;
    checks++;
    if (o.to || o.cyc + 1 != 5)
      begin errors++; $display("FAIL write_latency: got cycle %0d to %0d want 5", o.cyc + 1, o.to); end
    checks++;
    if ({o.a0, o.a1, o.f0, o.gr, o.busy} !== 5'b10001 || o.rd !== rdata_model)
      begin errors++; $display("FAIL write_ack: got a%b%b f%b g%b rd%h want 10 0 0 rd%h",
        o.a0, o.a1, o.f0, o.gr, o.rd, rdata_model); end
    checks++;
    if (o.ens != 1 || seen_q.size() != 1 || {seen_q[0].rw, seen_q[0].addr, seen_q[0].data} !== {1'b1, 6'h0A, 8'h00})
      begin errors++; $display("FAIL write_strobe: got %0d pulses want 1 with rw1 addr0a data00", o.ens); end
    @(negedge CLK_60M);
    checks++;
    if ({R0_ACK, BUSY} !== 2'b00)
      begin errors++; $display("FAIL ack_one_cycle: got ack%b busy%b want 0 0", R0_ACK, BUSY); end
    lg_model = 1'b0;
  endtask

  task automatic test_fail_retry;
    obs_t o;
    int lat;
    lat = 2;
    for (int k = 0; k < ATTEMPTS; k++) begin
      int d;
      d = $urandom_range(1, 3);
      plan_q.push_back('{K_FAIL, d, 8'h00});
      lat += 1 + d;
    end
    R1_RW = 1'b1; R1_ADDR = 6'h2C; R1_WDATA = 8'hC3; R1_REQ = 1'b1;
    serve(200, 0, o);
    R1_REQ = 1'b0;
    checks++;
    if (o.to || o.ens != ATTEMPTS)
      begin errors++; $display("FAIL fail_pulses: got %0d to %0d want %0d", o.ens, o.to, ATTEMPTS); end
    checks++;
    if ({o.a0, o.a1, o.f0, o.f1, o.gr} !== 5'b01011 || o.rd !== rdata_model || o.cyc + 1 != lat)
      begin errors++; $display("FAIL fail_ack: got a%b%b f%b%b g%b rd%h cyc%0d want 01 01 1 rd%h cyc%0d",
        o.a0, o.a1, o.f0, o.f1, o.gr, o.rd, o.cyc + 1, rdata_model, lat); end
    lg_model = 1'b1;
    @(negedge CLK_60M);
  endtask

  task automatic test_random;
    for (int r = 0; r < 30; r++) begin
      int mask, n;
      exp_t ex[2];
      obs_t o;
      logic [5:0] addr[2];
      logic [7:0] wd[2];
      logic rw[2];
      logic [7:0] rd_m;
      for (int q = 0; q < 2; q++) begin
        rw[q] = 1'($urandom); addr[q] = 6'($urandom); wd[q] = 8'($urandom);
      end
      mask = $urandom_range(1, 3);
      n = (mask == 3) ? 2 : 1;
      ex[0].idx = (mask == 3) ? int'(!lg_model) : int'(mask == 2);
      ex[1].idx = 1 - ex[0].idx;
      rd_m = rdata_model;
      for (int s = 0; s < n; s++) begin
        int att, lat;
        bit ok;
        att = 0; lat = 2; ok = 1'b0;
        while (att < ATTEMPTS && !ok) begin
          int k, d;
          plan_t p;
          k = $urandom_range(0, 9);
          d = $urandom_range(1, 4);
          p = '{(k < 4) ? K_DONE : (k < 8) ? K_FAIL : K_BOTH, d, 8'($urandom)};
          plan_q.push_back(p);
          lat += 1 + d;
          att++;
          if (p.kind != K_FAIL) begin
            ok = 1'b1;
            if (!rw[ex[s].idx]) rd_m = p.data;
          end
        end
        ex[s].att = att; ex[s].fail = !ok; ex[s].lat = lat; ex[s].rd = rd_m;
        ex[s].rw = rw[ex[s].idx]; ex[s].addr = addr[ex[s].idx]; ex[s].wd = wd[ex[s].idx];
      end
      R0_RW = rw[0]; R0_ADDR = addr[0]; R0_WDATA = wd[0];
      R1_RW = rw[1]; R1_ADDR = addr[1]; R1_WDATA = wd[1];
      R0_REQ = mask[0]; R1_REQ = mask[1];
      for (int s = 0; s < n; s++) begin
        bit bad;
        logic [3:0] want;
        serve(200, 0, o);
        if (ex[s].idx == 0) R0_REQ = 1'b0; else R1_REQ = 1'b0;
        want = (ex[s].idx == 0) ? {1'b1, 1'b0, ex[s].fail, 1'b0} : {1'b0, 1'b1, 1'b0, ex[s].fail};
        checks++;
        if (o.to || {o.a0, o.a1, o.f0, o.f1} !== want || o.gr !== 1'(ex[s].idx) || o.rd !== ex[s].rd)
          begin errors++; $display("FAIL rand_ack r%0d s%0d: got a%b%b f%b%b g%b rd%h want %b g%0d rd%h",
            r, s, o.a0, o.a1, o.f0, o.f1, o.gr, o.rd, want, ex[s].idx, ex[s].rd); end
        checks++;
        if (((s == 0) ? o.cyc + 1 : o.cyc) != ex[s].lat || o.ens != ex[s].att)
          begin errors++; $display("FAIL rand_timing r%0d s%0d: got lat %0d pulses %0d want %0d %0d",
            r, s, (s == 0) ? o.cyc + 1 : o.cyc, o.ens, ex[s].lat, ex[s].att); end
        bad = (seen_q.size() != ex[s].att);
        foreach (seen_q[i])
          if ({seen_q[i].rw, seen_q[i].addr, seen_q[i].data} !== {ex[s].rw, ex[s].addr, ex[s].wd}) bad = 1'b1;
        checks++;
        if (bad)
          begin errors++; $display("FAIL rand_strobe r%0d s%0d: got %0d strobes want %0d of rw%b addr%h data%h",
            r, s, seen_q.size(), ex[s].att, ex[s].rw, ex[s].addr, ex[s].wd); end
        lg_model = 1'(ex[s].idx);
      end
      rdata_model = rd_m;
      @(negedge CLK_60M);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    bit bad;
    for (int k = 0; k < ATTEMPTS; k++) plan_q.push_back('{K_SILENT, 0, 8'h00});
    R0_RW = 1'b0; R0_ADDR = 6'h3F; R0_REQ = 1'b1;
    serve(6000, 2, o);
    checks++;
    if (o.to || o.ens != ATTEMPTS || {o.a0, o.f0, o.gr} !== 3'b110 || o.rd !== rdata_model)
      begin errors++; $display("FAIL timeout_ack: got to%0d pulses %0d a%b f%b g%b rd%h want 4 1 1 0 rd%h",
        o.to, o.ens, o.a0, o.f0, o.gr, o.rd, rdata_model); end
    checks++;
    if (o.cyc + 1 != 2 + ATTEMPTS * (1 + int'(TIMEOUT)))
      begin errors++; $display("FAIL timeout_latency: got %0d want %0d",
        o.cyc + 1, 2 + ATTEMPTS * (1 + int'(TIMEOUT))); end
    bad = (seen_q.size() != ATTEMPTS);
    for (int i = 1; i < seen_q.size(); i++)
      if (seen_q[i].cyc - seen_q[i-1].cyc != int'(TIMEOUT) + 1) bad = 1'b1;
    checks++;
    if (bad)
      begin errors++; $display("FAIL timeout_spacing: got %0d strobes want %0d spaced %0d",
        seen_q.size(), ATTEMPTS, TIMEOUT + 1); end
    lg_model = 1'b0;
    @(negedge CLK_60M);
  endtask

  task automatic test_ready_and_reset;
    int e0;
    bit seen_ack;
    NRST_A_USB = 1'b0;
    @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
    lg_model = 1'b1;
    rdata_model = 8'h00;
    ULPI_READY = 1'b0;
    R1_RW = 1'b0; R1_ADDR = 6'h11; R1_REQ = 1'b1;
    repeat (3) @(negedge CLK_60M);
    R1_REQ = 1'b0;
    e0 = en_cnt;
    ULPI_READY = 1'b1;
    repeat (5) @(negedge CLK_60M);
    checks++;
    if (en_cnt != e0 || BUSY !== 1'b0)
      begin errors++; $display("FAIL dropped_req: got pulses %0d busy %b want 0 0", en_cnt - e0, BUSY); end
    ULPI_READY = 1'b0;
    R0_RW = 1'b0; R0_ADDR = 6'h15; R0_REQ = 1'b1; R1_REQ = 1'b1;
    repeat (8) @(negedge CLK_60M);
    checks++;
    if (en_cnt != e0 || BUSY !== 1'b0)
      begin errors++; $display("FAIL not_ready_hold: got pulses %0d busy %b want 0 0", en_cnt - e0, BUSY); end
    plan_q.delete();
    plan_q.push_back('{K_SILENT, 0, 8'h00});
    ULPI_READY = 1'b1;
    @(negedge CLK_60M);
    checks++;
    if ({REG_EN, BUSY, GRANT} !== 3'b110 || REG_ADDR !== 6'h15)
      begin errors++; $display("FAIL ready_grant: got en%b busy%b g%b addr%h want 1 1 0 addr15",
        REG_EN, BUSY, GRANT, REG_ADDR); end
    repeat (2) @(negedge CLK_60M);
    NRST_A_USB = 1'b0;
    #1;
    checks++;
    if ({R0_ACK, R1_ACK, R0_FAIL, R1_FAIL, REG_EN, REG_RW, BUSY, GRANT, RDATA, REG_ADDR, REG_DATA_I} !== 30'h0)
      begin errors++; $display("FAIL async_reset: got %h want 0",
        {R0_ACK, R1_ACK, R0_FAIL, R1_FAIL, REG_EN, REG_RW, BUSY, GRANT, RDATA, REG_ADDR, REG_DATA_I}); end
    @(negedge CLK_60M);
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    NRST_A_USB = 1'b1;
    plan_q.delete();
    seen_ack = 1'b0;
    repeat (20) begin
      @(negedge CLK_60M);
      if (R0_ACK || R1_ACK || REG_EN) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack)
      begin errors++; $display("FAIL abandoned_txn: got ack or strobe after reset want none"); end
  endtask

  initial begin
    checks = 0; errors = 0;
    NRST_A_USB = 1'b0; ULPI_READY = 1'b1;
    R0_REQ = 1'b0; R0_RW = 1'b0; R0_ADDR = '0; R0_WDATA = '0;
    R1_REQ = 1'b0; R1_RW = 1'b0; R1_ADDR = '0; R1_WDATA = '0;
    lg_model = 1'b1; rdata_model = 8'h00;
    test_reset;
    test_contention;
    test_single_write;
    test_fail_retry;
    test_random;
    test_timeout;
    test_ready_and_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
